// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing,
// shared-memory handshake on mem_ready and a sticky trap on memory wait timeout.
module multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IRWrite,
    output logic        IorD,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [1:0]  ALUOp,
    output logic        instr_done,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state_dbg
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        WB_MEM = 4'd6,
        MEM_WR = 4'd7,
        WB_ALU = 4'd8,
        BRANCH = 4'd9,
        HALT   = 4'd15
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] wait_cnt;
    logic          cls_i;
    logic          bus_err_q;
    logic          is_r, is_i, is_mem, is_br, is_stur;
    logic          in_wait, timeout;

    always_comb begin
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_mem = 1'b0;
        is_br  = 1'b0;
        casez (Op)
            11'b10001011000, 11'b11001011000, 11'b10001010000,
            11'b10101010000, 11'b10101011000, 11'b11101011000: is_r = 1'b1;
            11'b1001000100?, 11'b1101000100?,
            11'b1011000100?, 11'b1111000100?:                  is_i = 1'b1;
            11'b11111000010, 11'b11111000000:                  is_mem = 1'b1;
            11'b10110100???, 11'b01010100???:                  is_br = 1'b1;
            default: ;
        endcase
    end

    assign is_stur = (Op == 11'b11111000000);
    assign in_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // The WAIT_MAX-th consecutive low cycle is the one seen with wait_cnt == WAIT_MAX-1.
    assign timeout = in_wait && !mem_ready && (wait_cnt == CW'(WAIT_MAX - 1));

    always_comb begin
        nxt = state;
        case (state)
            FETCH:   nxt = timeout ? HALT : (mem_ready ? DECODE : FETCH);
            DECODE:  nxt = is_r ? EXEC_R : is_i ? EXEC_I : is_mem ? ADDR :
                           is_br ? BRANCH : FETCH;
            EXEC_R:  nxt = WB_ALU;
            EXEC_I:  nxt = WB_ALU;
            WB_ALU:  nxt = FETCH;
            ADDR:    nxt = is_stur ? MEM_WR : MEM_RD;
            MEM_RD:  nxt = timeout ? HALT : (mem_ready ? WB_MEM : MEM_RD);
            WB_MEM:  nxt = FETCH;
            MEM_WR:  nxt = timeout ? HALT : (mem_ready ? FETCH : MEM_WR);
            BRANCH:  nxt = FETCH;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            cls_i     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= nxt;
            // Leaving a wait state (including wait-to-wait hops) always clears the count.
            if (in_wait && !mem_ready && nxt == state)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state == DECODE)
                cls_i <= is_i;
            if (nxt == HALT)
                bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        Reg2Loc    = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        ALUOp      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    if (!(is_r || is_i || is_mem || is_br)) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                EXEC_R: ALUOp = 2'b10;
                EXEC_I: begin
                    ALUSrc = 1'b1;
                    ALUOp  = 2'b11;
                end
                WB_ALU: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    ALUSrc     = cls_i;
                    ALUOp      = cls_i ? 2'b11 : 2'b10;
                end
                ADDR: begin
                    ALUSrc  = 1'b1;
                    Reg2Loc = is_stur;
                end
                MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                WB_MEM: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WR: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    Reg2Loc    = 1'b1;
                    instr_done = mem_ready;
                end
                BRANCH: begin
                    Reg2Loc    = 1'b1;
                    ALUOp      = 2'b01;
                    Branch     = 1'b1;
                    PCSrc      = 1'b1;
                    PCWrite    = Zero;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus_err   = bus_err_q;
    assign state_dbg = reset ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/control tables for each
// instruction class, memory waits, timeout trap and mid-instruction reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0, reset2 = 1'b0;
    logic [10:0] Op = '0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0, mem_ready2 = 1'b0;

    logic PCWrite, PCSrc, IRWrite, IorD, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
    logic MemRead, MemWrite, Branch, instr_done, illegal, bus_err;
    logic [1:0] ALUOp;
    logic [3:0] state_dbg;

    logic PCWrite2, PCSrc2, IRWrite2, IorD2, Reg2Loc2, ALUSrc2, MemtoReg2, RegWrite2;
    logic MemRead2, MemWrite2, Branch2, instr_done2, illegal2, bus_err2;
    logic [1:0] ALUOp2;
    logic [3:0] state_dbg2;

    int n_checks = 0;
    int n_fail   = 0;

    // {PCWrite,PCSrc,IRWrite,IorD,Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,instr_done,illegal}
    logic [14:0] ctrl, ctrl2;
    assign ctrl  = {PCWrite, PCSrc, IRWrite, IorD, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                    MemRead, MemWrite, Branch, ALUOp, instr_done, illegal};
    assign ctrl2 = {PCWrite2, PCSrc2, IRWrite2, IorD2, Reg2Loc2, ALUSrc2, MemtoReg2, RegWrite2,
                    MemRead2, MemWrite2, Branch2, ALUOp2, instr_done2, illegal2};

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .IorD(IorD),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
        .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    multicycle_ctrl #(.WAIT_MAX(4)) dut4 (
        .clk(clk), .reset(reset2), .Op(Op), .Zero(Zero), .mem_ready(mem_ready2),
        .PCWrite(PCWrite2), .PCSrc(PCSrc2), .IRWrite(IRWrite2), .IorD(IorD2),
        .Reg2Loc(Reg2Loc2), .ALUSrc(ALUSrc2), .MemtoReg(MemtoReg2), .RegWrite(RegWrite2),
        .MemRead(MemRead2), .MemWrite(MemWrite2), .Branch(Branch2), .ALUOp(ALUOp2),
        .instr_done(instr_done2), .illegal(illegal2), .bus_err(bus_err2), .state_dbg(state_dbg2)
    );

    // Leaves the bench at posedge+1 of cycle 1 (first FETCH cycle).
    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        #2;
        n_checks++;
        if (ctrl !== 15'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 15'd0);
        end
        n_checks++;
        if (state_dbg !== 4'd0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got state %0d bus_err %b want 0 0", state_dbg, bus_err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 15'b000000001000000 || state_dbg !== 4'd0) begin
            n_fail++; $display("FAIL reset_release: got %b st %0d want %b st 0", ctrl, state_dbg, 15'b000000001000000);
        end
    endtask

    // ADD with zero-wait memory: FETCH, DECODE, EXEC_R, WB_ALU, back to FETCH
    task automatic test_add();
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd0};
        logic [14:0] ec [4] = '{15'b101000001000000, 15'b000000000000000,
                                15'b000000000001000, 15'b000000010001010};
        Op = 11'b10001011000;
        mem_ready = 1'b1;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (state_dbg !== es[i]) begin
                n_fail++; $display("FAIL add_state cyc %0d: got %0d want %0d", i + 1, state_dbg, es[i]);
            end
            if (i < 4) begin
                n_checks++;
                if (ctrl !== ec[i]) begin
                    n_fail++; $display("FAIL add_ctrl cyc %0d: got %b want %b", i + 1, ctrl, ec[i]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // LDUR with 3 low cycles in MEM_RD: 8 cycles total
    task automatic test_ldur_wait();
        logic [3:0]  es [9] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd0};
        logic        mr [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [14:0] ec [8] = '{15'b101000001000000, 15'b000000000000000,
                                15'b000001000000000, 15'b000100001000000,
                                15'b000100001000000, 15'b000100001000000,
                                15'b000100001000000, 15'b000000110000010};
        Op = 11'b11111000010;
        mem_ready = 1'b1;
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (state_dbg !== es[i]) begin
                n_fail++; $display("FAIL ldur_state cyc %0d: got %0d want %0d", i + 1, state_dbg, es[i]);
            end
            if (i < 8) begin
                n_checks++;
                if (ctrl !== ec[i]) begin
                    n_fail++; $display("FAIL ldur_ctrl cyc %0d: got %b want %b", i + 1, ctrl, ec[i]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cbz();
        for (int z = 1; z >= 0; z--) begin
            Op = 11'b10110100000;
            Zero = z[0];
            mem_ready = 1'b1;
            pulse_reset();
            @(posedge clk); #1;
            @(posedge clk); #1;
            #1;
            n_checks++;
            if (state_dbg !== 4'd9 || ctrl !== {z[0], 14'b10010000010110}) begin
                n_fail++; $display("FAIL cbz_branch zero=%0d: got st %0d ctrl %b want st 9 ctrl %b",
                                   z, state_dbg, ctrl, {z[0], 14'b10010000010110});
            end
            @(posedge clk); #1;
            n_checks++;
            if (state_dbg !== 4'd0) begin
                n_fail++; $display("FAIL cbz_return zero=%0d: got %0d want 0", z, state_dbg);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_illegal();
        Op = 11'b00000000000;
        mem_ready = 1'b1;
        pulse_reset();
        @(posedge clk); #1;
        #1;
        n_checks++;
        if (state_dbg !== 4'd1 || ctrl !== 15'b000000000000011) begin
            n_fail++; $display("FAIL illegal_decode: got st %0d ctrl %b want st 1 ctrl %b",
                               state_dbg, ctrl, 15'b000000000000011);
        end
        @(posedge clk); #1;
        n_checks++;
        if (state_dbg !== 4'd0) begin
            n_fail++; $display("FAIL illegal_next: got %0d want 0", state_dbg);
        end
    endtask

    // ADDI then zero-wait STUR without reset in between: class latch and STUR latency
    task automatic test_back_to_back();
        logic [3:0]  es [9] = '{4'd0, 4'd1, 4'd3, 4'd8, 4'd0, 4'd1, 4'd4, 4'd7, 4'd0};
        logic [14:0] ec [8] = '{15'b101000001000000, 15'b000000000000000,
                                15'b000001000001100, 15'b000001010001110,
                                15'b101000001000000, 15'b000000000000000,
                                15'b000011000000000, 15'b000110000100010};
        Op = 11'b10010001000;
        mem_ready = 1'b1;
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 4) Op = 11'b11111000000;
            #1;
            n_checks++;
            if (state_dbg !== es[i]) begin
                n_fail++; $display("FAIL b2b_state cyc %0d: got %0d want %0d", i + 1, state_dbg, es[i]);
            end
            if (i < 8) begin
                n_checks++;
                if (ctrl !== ec[i]) begin
                    n_fail++; $display("FAIL b2b_ctrl cyc %0d: got %b want %b", i + 1, ctrl, ec[i]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stur_reset();
        Op = 11'b11111000000;
        mem_ready = 1'b1;
        pulse_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== 4'd7 || ctrl !== 15'b000110000100000) begin
            n_fail++; $display("FAIL stur_memwr: got st %0d ctrl %b want st 7 ctrl %b",
                               state_dbg, ctrl, 15'b000110000100000);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0 || ctrl !== 15'd0 || state_dbg !== 4'd0) begin
            n_fail++; $display("FAIL stur_abort: got MemWrite %b ctrl %b st %0d want 0 0 0",
                               MemWrite, ctrl, state_dbg);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== 4'd0 || MemRead !== 1'b1) begin
            n_fail++; $display("FAIL stur_resume: got st %0d MemRead %b want 0 1", state_dbg, MemRead);
        end
    endtask

    task automatic test_timeout();
        // mem_ready rising on the 4th cycle still beats the trap (only 3 lows)
        mem_ready2 = 1'b0;
        reset2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        mem_ready2 = 1'b1;
        @(posedge clk); #1;
        mem_ready2 = 1'b0;
        #1;
        n_checks++;
        if (state_dbg2 !== 4'd1 || bus_err2 !== 1'b0) begin
            n_fail++; $display("FAIL timeout_edge: got st %0d bus_err %b want 1 0", state_dbg2, bus_err2);
        end

        reset2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            if (i == 4) begin
                n_checks++;
                if (state_dbg2 !== 4'd0 || ctrl2 !== 15'b000000001000000) begin
                    n_fail++; $display("FAIL timeout_wait: got st %0d ctrl %b want st 0 ctrl %b",
                                       state_dbg2, ctrl2, 15'b000000001000000);
                end
            end
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (state_dbg2 !== 4'd15 || bus_err2 !== 1'b1 || ctrl2 !== 15'd0) begin
            n_fail++; $display("FAIL timeout_halt: got st %0d bus_err %b ctrl %b want 15 1 0",
                               state_dbg2, bus_err2, ctrl2);
        end
        mem_ready2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        #1;
        n_checks++;
        if (state_dbg2 !== 4'd15 || bus_err2 !== 1'b1 || ctrl2 !== 15'd0) begin
            n_fail++; $display("FAIL halt_sticky: got st %0d bus_err %b ctrl %b want 15 1 0",
                               state_dbg2, bus_err2, ctrl2);
        end
        reset2 = 1'b1;
        #1;
        n_checks++;
        if (bus_err2 !== 1'b0 || state_dbg2 !== 4'd0) begin
            n_fail++; $display("FAIL halt_clear: got bus_err %b st %0d want 0 0", bus_err2, state_dbg2);
        end
        @(posedge clk); #1;
        reset2 = 1'b0;
    endtask

    initial begin
        reset2 = 1'b1;
        test_reset();
        test_add();
        test_ldur_wait();
        test_cbz();
        test_illegal();
        test_back_to_back();
        test_stur_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
